// File: rtl/lbp_pkg.sv
// lbp_pkg: default geometry, scheduler states and 3x3 window slot indices
package lbp_pkg;
   localparam int DEF_IMG_W = 128;
   localparam int DEF_IMG_H = 128;
   localparam int DEF_ADDR_W = 14;
   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT, DONE} state_t;
   localparam int G_TL = 0;
   localparam int G_TM = 1;
   localparam int G_TR = 2;
   localparam int G_ML = 3;
   localparam int G_C = 4;
   localparam int G_MR = 5;
   localparam int G_BL = 6;
   localparam int G_BM = 7;
   localparam int G_BR = 8;
endpackage

// File: rtl/lbp_line_buffer.sv
// lbp_line_buffer: two previous image rows, read and shifted one column per capture
module lbp_line_buffer #(
   parameter int IMG_W = 128
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(IMG_W)-1:0] col,
   input  logic [7:0]               p,
   output logic [7:0]               top,
   output logic [7:0]               mid
);
   logic [7:0] lb_a [IMG_W];
   logic [7:0] lb_b [IMG_W];
   assign top = lb_a[col];
   assign mid = lb_b[col];
   always_ff @(posedge clk)
      if (we) begin
         lb_a[col] <= lb_b[col];
         lb_b[col] <= p;
      end
endmodule

// File: rtl/lbp_window_sched.sv
// lbp_window_sched: single-pass raster fetch that emits the 3x3 window of every interior pixel
module lbp_window_sched
   import lbp_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [7:0]        gray_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [ADDR_W-1:0] win_addr,
   output logic [71:0]       win_data,
   output logic              finish
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   state_t state, state_nx;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [ADDR_W-1:0] row_a, col_a;
   logic [7:0] top, mid;
   logic [47:0] hist;
   logic [71:0] win_nx;
   logic col_end, last_px, emit_now, frame_end;
   assign row_a = ADDR_W'(row);
   assign col_a = ADDR_W'(col);
   assign col_end = col == CW'(IMG_W - 1);
   assign last_px = col_end && row == RW'(IMG_H - 1);
   assign emit_now = row >= RW'(2) && col >= CW'(2);
   // counters only return to the origin by wrapping past the last pixel
   assign frame_end = row == '0 && col == '0;
   assign gray_addr = row_a * ADDR_W'(IMG_W) + col_a;
   assign win_nx = {gray_data, hist[47:32], mid, hist[31:16], top, hist[15:0]};
   lbp_line_buffer #(.IMG_W(IMG_W)) u_lb (
      .clk(clk),
      .we(state == CAPTURE),
      .col(col),
      .p(gray_data),
      .top(top),
      .mid(mid)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      gray_req = state == FETCH;
      win_valid = state == EMIT;
      finish = state == DONE;
      case (state)
         IDLE:    state_nx = gray_ready ? FETCH : IDLE;
         FETCH:   state_nx = CAPTURE;
         CAPTURE: state_nx = emit_now ? EMIT : last_px ? DONE : gray_ready ? FETCH : IDLE;
         EMIT:    state_nx = !win_ready ? EMIT : frame_end ? DONE : gray_ready ? FETCH : IDLE;
         DONE:    state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         row <= '0;
         col <= '0;
         win_addr <= '0;
         win_data <= '0;
      end else if (state == CAPTURE) begin
         col <= col_end ? '0 : col + 1'b1;
         if (col_end) row <= row + 1'b1;
         if (emit_now) begin
            win_addr <= (row_a - ADDR_W'(1)) * ADDR_W'(IMG_W) + col_a - ADDR_W'(1);
            win_data <= win_nx;
         end
      end
   // stale history is harmless: no window is emitted before two fresh columns exist
   always_ff @(posedge clk)
      if (state == CAPTURE) hist <= {win_nx[8*G_BM +: 16], win_nx[8*G_C +: 16], win_nx[8*G_TM +: 16]};
endmodule

// File: tb/tb_lbp_window_sched.sv
// tb_lbp_window_sched: random-image scoreboard bench for the LBP window scheduler
module tb_lbp_window_sched;
   localparam int W = 128;
   localparam int H = 128;
   localparam int AW = 14;
   localparam int NPIX = W * H;
   localparam int NWIN = (W - 2) * (H - 2);
   logic clk = 1'b0;
   logic reset, gray_ready, gray_req, win_valid, win_ready, finish;
   logic [AW-1:0] gray_addr, win_addr;
   logic [7:0] gray_data;
   logic [71:0] win_data;
   logic [7:0] mem [NPIX];
   int checks = 0, errors = 0, cyc = 0;
   int req_cnt, first_req_cyc, first_valid_cyc;
   int req_q[$];
   int acc_addr_q[$];
   logic [71:0] acc_data_q[$];

   always #5 clk = ~clk;

   lbp_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
      .gray_addr(gray_addr), .gray_data(gray_data), .win_valid(win_valid),
      .win_ready(win_ready), .win_addr(win_addr), .win_data(win_data), .finish(finish)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (gray_req) gray_data <= mem[gray_addr];
   end

   always @(negedge clk)
      if (!reset) begin
         if (gray_req) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            req_cnt++;
            req_q.push_back(int'(gray_addr));
         end
         if (win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (win_valid && win_ready) begin
            acc_addr_q.push_back(int'(win_addr));
            acc_data_q.push_back(win_data);
         end
      end

   // golden neighbourhood of centre (r,c), g0 top-left, row-major
   function automatic logic [71:0] gold(input int r, input int c);
      logic [71:0] g;
      for (int k = 0; k < 9; k++) g[8*k +: 8] = mem[(r - 1 + k / 3) * W + (c - 1 + k % 3)];
      return g;
   endfunction

   task automatic load_and_reset(input bit random_img);
      reset = 1'b1;
      gray_ready = 1'b0;
      win_ready = 1'b0;
      for (int i = 0; i < NPIX; i++) mem[i] = random_img ? 8'($urandom) : 8'(i);
      req_q.delete();
      acc_addr_q.delete();
      acc_data_q.delete();
      req_cnt = 0;
      first_req_cyc = -1;
      first_valid_cyc = -1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      gray_ready = 1'b0;
      win_ready = 1'b0;
      req_cnt = 0;
      first_req_cyc = -1;
      first_valid_cyc = -1;
      #1;
      checks++; if (gray_req !== 1'b0) begin errors++; $display("FAIL reset_gray_req: got %b expected 0", gray_req); end
      checks++; if (gray_addr !== '0) begin errors++; $display("FAIL reset_gray_addr: got %0d expected 0", gray_addr); end
      checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
      checks++; if (win_addr !== '0) begin errors++; $display("FAIL reset_win_addr: got %0d expected 0", win_addr); end
      checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_win_data: got %h expected 0", win_data); end
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (req_cnt !== 0) begin errors++; $display("FAIL idle_no_req: got %0d requests expected 0", req_cnt); end
   endtask

   task automatic test_first_window_stall;
      logic [71:0] exp_win;
      exp_win = 72'h02_01_00_82_81_80_02_01_00;
      load_and_reset(1'b0);
      gray_ready = 1'b1;
      for (int t = 0; t < 2000 && win_valid !== 1'b1; t++) @(negedge clk);
      checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL first_win_timeout: win_valid got %b expected 1", win_valid); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (win_valid !== 1'b1 || gray_req !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: valid/req got %b/%b expected 1/0", i, win_valid, gray_req); end
         checks++; if (win_addr !== 14'd129 || win_data !== exp_win) begin errors++; $display("FAIL stall_data_%0d: got %0d/%h expected 129/%h", i, win_addr, win_data, exp_win); end
         if (i < 4) @(negedge clk);
      end
      checks++; if (first_valid_cyc - first_req_cyc !== 518) begin errors++; $display("FAIL first_win_latency: got %0d expected 518", first_valid_cyc - first_req_cyc); end
      win_ready = 1'b1;
      @(negedge clk);
      win_ready = 1'b0;
      checks++; if (win_valid !== 1'b0 || gray_req !== 1'b1) begin errors++; $display("FAIL resume_after_accept: valid/req got %b/%b expected 0/1", win_valid, gray_req); end
      checks++; if (gray_addr !== 14'd259) begin errors++; $display("FAIL resume_addr: got %0d expected 259", gray_addr); end
      checks++; if (acc_addr_q.size() !== 1) begin errors++; $display("FAIL stall_accepts: got %0d expected 1", acc_addr_q.size()); end
   endtask

   task automatic test_reset_mid_frame;
      load_and_reset(1'b1);
      gray_ready = 1'b1;
      win_ready = 1'b1;
      for (int t = 0; t < 20000 && req_cnt <= 5000; t++) begin @(negedge clk); #1; end
      checks++; if (req_cnt <= 5000) begin errors++; $display("FAIL mid_reset_reach: got %0d requests expected >5000", req_cnt); end
      #1 reset = 1'b1;
      #1;
      checks++; if ({gray_req, win_valid, finish} !== 3'b000 || gray_addr !== '0 || win_addr !== '0 || win_data !== '0) begin
         errors++; $display("FAIL async_reset_outputs: req/valid/fin %b%b%b addr %0d waddr %0d data %h expected all 0", gray_req, win_valid, finish, gray_addr, win_addr, win_data);
      end
      load_and_reset(1'b1);
      gray_ready = 1'b1;
      win_ready = 1'b1;
      for (int t = 0; t < 2000 && acc_addr_q.size() == 0; t++) @(negedge clk);
      #1;
      checks++; if (acc_addr_q.size() == 0) begin errors++; $display("FAIL restart_timeout: got 0 windows expected 1"); end
      else begin
         checks++; if (req_q[0] !== 0) begin errors++; $display("FAIL restart_first_addr: got %0d expected 0", req_q[0]); end
         checks++; if (acc_addr_q[0] !== 129) begin errors++; $display("FAIL restart_win_addr: got %0d expected 129", acc_addr_q[0]); end
         checks++; if (acc_data_q[0] !== gold(1, 1)) begin errors++; $display("FAIL restart_win_data: got %h expected %h", acc_data_q[0], gold(1, 1)); end
         checks++; if (first_valid_cyc - first_req_cyc !== 518) begin errors++; $display("FAIL restart_latency: got %0d expected 518", first_valid_cyc - first_req_cyc); end
      end
   endtask

   task automatic test_full_frame;
      int gap_at, gap_left, snap, bad, first_bad, idx, seen;
      gap_at = 40 * W + 60;
      gap_left = -1;
      snap = 0;
      load_and_reset(1'b1);
      gray_ready = 1'b1;
      for (int t = 0; t < 70000 && finish !== 1'b1; t++) begin
         @(posedge clk);
         #1;
         win_ready = $urandom_range(7) != 0;
         if (gap_left < 0 && req_cnt == gap_at) begin
            gray_ready = 1'b0;
            gap_left = 10;
            snap = req_cnt;
         end else if (gap_left > 0) begin
            gap_left--;
            if (gap_left == 0) begin
               checks++; if (req_cnt !== snap) begin errors++; $display("FAIL gap_no_req: got %0d requests expected %0d", req_cnt, snap); end
               gray_ready = 1'b1;
            end
         end
      end
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL frame_timeout: finish got %b expected 1", finish); end
      checks++; if (acc_addr_q.size() !== NWIN) begin errors++; $display("FAIL frame_windows: got %0d expected %0d", acc_addr_q.size(), NWIN); end
      checks++; if (req_cnt !== NPIX) begin errors++; $display("FAIL frame_requests: got %0d expected %0d", req_cnt, NPIX); end
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < req_q.size(); i++)
         if (req_q[i] !== i) begin bad++; if (first_bad < 0) first_bad = i; end
      checks++; if (bad !== 0) begin errors++; $display("FAIL raster_order: %0d bad, first at %0d got %0d expected %0d", bad, first_bad, req_q[first_bad], first_bad); end
      checks++; if (req_q.size() <= gap_at || req_q[gap_at] !== gap_at) begin errors++; $display("FAIL gap_successor: got %0d expected %0d", req_q.size() > gap_at ? req_q[gap_at] : -1, gap_at); end
      bad = 0;
      first_bad = -1;
      idx = 0;
      for (int r = 1; r < H - 1; r++)
         for (int c = 1; c < W - 1; c++) begin
            if (idx >= acc_addr_q.size() || acc_addr_q[idx] !== r * W + c || acc_data_q[idx] !== gold(r, c)) begin
               bad++;
               if (first_bad < 0) first_bad = r * W + c;
            end
            idx++;
         end
      checks++; if (bad !== 0) begin errors++; $display("FAIL window_contents: %0d bad windows, first centre expected %0d", bad, first_bad); end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         gray_ready = $urandom_range(1);
         win_ready = $urandom_range(1);
         if (finish !== 1'b1 || win_valid !== 1'b0 || gray_req !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL finish_sticky: %0d bad cycles expected 0", seen); end
   endtask

   initial begin
      test_reset();
      test_first_window_stall();
      test_reset_mid_frame();
      test_full_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
